// File: rtl/wave_sample_scheduler_pkg.sv
// Shared constants and FSM encoding for the wave sample scheduler slice.
package wave_pkg;

    // Default fractional width of a generator sample; the sample is N_FRAC+1 bits, signed.
    localparam int N_FRAC_DEF = 7;
    localparam int SAMPLE_W   = N_FRAC_DEF + 1;

    // Scheduler FSM encoding.
    localparam logic IDLE_ENC = 1'b0;
    localparam logic WAIT_ENC = 1'b1;

    typedef enum logic {
        IDLE = IDLE_ENC,
        WAIT = WAIT_ENC
    } state_e;

endpackage

// File: rtl/wave_sample_scheduler_if.sv
// Request/response link between the scheduler and the sine generator.
// The scheduler is the master: it issues the next-data strobe and
// receives the valid strobe plus the signed sample.
interface wave_sample_scheduler_if #(
    parameter int N_FRAC = 7
) ();

    logic                     gen_strobe_o;
    logic                     gen_valid_i;
    logic signed [N_FRAC:0]   gen_data_i;

    modport master (
        output gen_strobe_o,
        input  gen_valid_i,
        input  gen_data_i
    );

    modport slave (
        input  gen_strobe_o,
        output gen_valid_i,
        output gen_data_i
    );

endinterface

// File: rtl/wave_sample_scheduler_sample_rate_divider.sv
// Free-running tick divider: one tick every divider_i+1 enabled cycles,
// first tick in the first enabled cycle. divider_i is only sampled on reload.
module sample_rate_divider #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [DIV_WIDTH-1:0] divider_i,
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] count_q;

    assign tick_o = enable_i && (count_q == '0);

    // Reload on tick, count down otherwise; parked at zero while disabled.
    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge value of its inputs, independent of block order.
        if (!rst_i) begin
            count_q <= '0;
        end else if (!enable_i) begin
            count_q <= '0;
        end else if (count_q == '0) begin
            count_q <= divider_i;
        end else begin
            count_q <= count_q - DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/wave_sample_scheduler.sv
// Sample scheduler: issues generator requests at the divided sample rate,
// captures returned samples, and flags dropped ticks and lost responses.
module wave_sample_scheduler
    import wave_pkg::*;
#(
    parameter int N_FRAC    = N_FRAC_DEF,
    parameter int DIV_WIDTH = 8,
    parameter int TIMEOUT   = 15
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic [DIV_WIDTH-1:0]   divider_i,
    input  logic                   clr_i,
    wave_sample_scheduler_if.master gen,
    output logic signed [N_FRAC:0] sample_o,
    output logic                   sample_valid_o,
    output logic                   busy_o,
    output logic                   overrun_o,
    output logic                   timeout_o
);

    localparam int TIMER_W = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    logic tick;

    state_e                 state_q,        state_d;
    logic [TIMER_W-1:0]     timer_q,        timer_d;
    logic                   strobe_q,       strobe_d;
    logic signed [N_FRAC:0] sample_q,       sample_d;
    logic                   sample_valid_q, sample_valid_d;
    logic                   overrun_q,      overrun_d;
    logic                   timeout_q,      timeout_d;

    sample_rate_divider #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_divider (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .enable_i  (enable_i),
        .divider_i (divider_i),
        .tick_o    (tick)
    );

    // Next-state, timer, capture and flag logic; every output is registered below.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves a value unassigned and no latch is inferred.
        state_d        = state_q;
        timer_d        = timer_q;
        strobe_d       = 1'b0;
        sample_valid_d = 1'b0;
        sample_d       = sample_q;
        // Clear first; any set event below overrides it in the same cycle.
        overrun_d      = overrun_q && !clr_i;
        timeout_d      = timeout_q && !clr_i;

        unique case (state_q)
            IDLE: begin
                // A valid strobe with nothing outstanding is ignored.
                if (tick) begin
                    strobe_d = 1'b1;
                    state_d  = WAIT;
                    timer_d  = '0;
                end
            end
            WAIT: begin
                timer_d = timer_q + TIMER_W'(1);
                if (gen.gen_valid_i) begin
                    sample_d       = gen.gen_data_i;
                    sample_valid_d = 1'b1;
                    if (tick) begin
                        // Back-to-back: the response and the next tick coincide.
                        strobe_d = 1'b1;
                        timer_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (tick) begin
                        overrun_d = 1'b1;
                    end
                    if (timer_q == TIMER_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, timer and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            strobe_q       <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            strobe_q       <= strobe_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            overrun_q      <= overrun_d;
            timeout_q      <= timeout_d;
        end
    end

    assign gen.gen_strobe_o = strobe_q;
    assign sample_o         = sample_q;
    assign sample_valid_o   = sample_valid_q;
    assign busy_o           = (state_q == WAIT);
    assign overrun_o        = overrun_q;
    assign timeout_o        = timeout_q;

endmodule
